// File: rtl/div_seq_pkg.sv
// Shared ALU opcode constants and divide-sequencer state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package div_seq_pkg;

    // 5-bit ALU opcode values, shared with the ALU decode.
    localparam logic [4:0] ALU_OP_DIV = 5'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between decode/control and the divide sequencer.
// Latency: n/a (wires only).
// Backpressure: requester must hold off while busy; starts seen while busy are dropped.
// Ports: start/op/ai/bi from control; busy/done/quo/rem/dz back from the divider.
interface div_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [5:0]       op;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;

    modport master (
        output start, op, ai, bi,
        input  busy, done, quo, rem, dz
    );

    modport slave (
        input  start, op, ai, bi,
        output busy, done, quo, rem, dz
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration producing one quotient bit.
// Latency: combinational.
// Backpressure: none.
// Ports: r_i/q_i/div_i current partial remainder, quotient shift reg, divisor; r_o/q_o next values.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    // Shifted remainder needs one extra bit: r_i < divisor, so 2*r_i+1 fits in WIDTH+1.
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        r_sh  = {r_i, q_i[WIDTH-1]};
        trial = r_sh - {1'b0, div_i};
        // trial[WIDTH] set means the subtraction went negative: restore.
        if (trial[WIDTH]) begin
            r_o = r_sh[WIDTH-1:0];
        end else begin
            r_o = trial[WIDTH-1:0];
        end
        q_o = {q_i[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned divider (restoring, one quotient bit per clock) for the ALU divide opcode.
// Latency: WIDTH+1 cycles start->done; 1 cycle for divide-by-zero; issue interval WIDTH+2.
// Backpressure: busy high in CALC/DONE; start is only accepted in IDLE and is not queued.
// Ports: clk, reset_n (async active-low), bus (slave): start/op/ai/bi in, busy/done/quo/rem/dz out.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int         WIDTH  = 8,
    parameter logic [5:0] OP_DIV = {1'b0, ALU_OP_DIV}
) (
    input  logic      clk,
    input  logic      reset_n,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i   (r_q),
        .q_i   (q_q),
        .div_i (div_q),
        .r_o   (step_r),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.op == OP_DIV)) begin
                    busy_d = 1'b1;
                    if (bus.bi != '0) begin
                        div_d   = bus.bi;
                        q_d     = bus.ai;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        dz_d    = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        q_d     = '1;
                        r_d     = bus.ai;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.quo  = q_q;
    assign bus.rem  = r_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: reset, operand corners, divide-by-zero, start qualification,
// mid-operation reset and a randomised sweep checked against a reference quotient/remainder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_div_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Present one start for one cycle; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
        @(negedge clk);
        bus.start = 1'b1;
        bus.ai    = a;
        bus.bi    = b;
        bus.op    = o;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts cycles since acceptance until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                           input logic edz);
        int lat;
        issue(a, b, 6'd14);
        check({tag, "_busy"}, 16'(bus.busy), 16'd1);
        wait_done(lat);
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_quo"}, 16'(bus.quo), 16'(eq));
        check({tag, "_rem"}, 16'(bus.rem), 16'(er));
        check({tag, "_dz"},  16'(bus.dz),  16'(edz));
    endtask

    initial begin
        int lat;
        logic [7:0] a, b, eq, er;

        bus.start = 1'b0;
        bus.op    = 6'd0;
        bus.ai    = 8'd0;
        bus.bi    = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_quo",  16'(bus.quo),  16'd0);
        check("rst_rem",  16'(bus.rem),  16'd0);
        check("rst_dz",   16'(bus.dz),   16'd0);
        reset_n = 1'b1;

        // Basic divide and the cycle after done
        run_div("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
        @(negedge clk);
        check("d100_7_done_pulse", 16'(bus.done), 16'd0);
        check("d100_7_busy_drop",  16'(bus.busy), 16'd0);
        check("d100_7_hold_quo",   16'(bus.quo),  16'd14);

        // Edge operands
        run_div("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
        run_div("d3_200", 8'd3, 8'd200, 9, 8'd0, 8'd3, 1'b0);

        // Divide by zero then a normal op clears dz
        run_div("dz5a", 8'h5A, 8'd0, 1, 8'hFF, 8'h5A, 1'b1);
        @(negedge clk);
        check("dz5a_busy_drop", 16'(bus.busy), 16'd0);
        check("dz5a_hold_dz",   16'(bus.dz),   16'd1);
        run_div("d10_3", 8'd10, 8'd3, 9, 8'd3, 8'd1, 1'b0);

        // Wrong opcode is ignored
        issue(8'd50, 8'd5, 6'd13);
        check("op13_busy", 16'(bus.busy), 16'd0);
        @(negedge clk);
        check("op13_done", 16'(bus.done), 16'd0);
        check("op13_quo",  16'(bus.quo),  16'd3);

        // Start during CALC ignored; original result completes
        issue(8'd100, 8'd7, 6'd14);
        @(negedge clk);
        bus.start = 1'b1; bus.ai = 8'd50; bus.bi = 8'd5; bus.op = 6'd14;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("calc_start_quo", 16'(bus.quo), 16'd14);
        check("calc_start_rem", 16'(bus.rem), 16'd2);
        // Start held during the DONE cycle is also dropped
        bus.start = 1'b1; bus.ai = 8'd50; bus.bi = 8'd5; bus.op = 6'd14;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_start_busy", 16'(bus.busy), 16'd0);
        @(negedge clk);
        check("done_start_idle", 16'(bus.busy), 16'd0);
        // Re-issue in IDLE accepted
        run_div("reissue", 8'd50, 8'd5, 9, 8'd10, 8'd0, 1'b0);

        // Reset in the 4th CALC cycle
        issue(8'd100, 8'd7, 6'd14);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 16'(bus.busy), 16'd0);
        check("mid_rst_done", 16'(bus.done), 16'd0);
        check("mid_rst_quo",  16'(bus.quo),  16'd0);
        check("mid_rst_rem",  16'(bus.rem),  16'd0);
        check("mid_rst_dz",   16'(bus.dz),   16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_div("post_rst", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);

        // Randomised sweep, issued back-to-back at the minimum interval
        for (int i = 0; i < 1000; i++) begin
            case (i)
                0: begin a = 8'd0;   b = 8'd0;   end
                1: begin a = 8'd255; b = 8'd255; end
                2: begin a = 8'd255; b = 8'd0;   end
                3: begin a = 8'd0;   b = 8'd255; end
                default: begin
                    a = 8'($urandom_range(0, 255));
                    b = 8'($urandom_range(0, 255));
                end
            endcase
            if (b == 8'd0) begin
                eq = 8'hFF; er = a;
            end else begin
                eq = a / b; er = a % b;
            end
            run_div("rand", a, b, (b == 8'd0) ? 1 : 9, eq, er, (b == 8'd0));
            if (b != 8'd0) begin
                check("rand_inv", 16'(bus.quo) * 16'(b) + 16'(bus.rem), 16'(a));
                check("rand_rem_lt", 16'(bus.rem < b), 16'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
